// File: rtl/clb_param.sv
// Parametrised configurable logic block: NUM_LE K-input LUT elements, channel routing and a
// daisy-chainable shadow configuration chain with atomic commit. Optional carry chain: CLB_CARRY_EN.
module clb_param #(
  parameter int LUT_K   = 4,
  parameter int NUM_LE  = 2,
  parameter int CHAN_W  = 2,
  parameter int LOCAL_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CHAN_W-1:0]  from_north,
  input  logic [CHAN_W-1:0]  from_south,
  input  logic [CHAN_W-1:0]  from_east,
  input  logic [CHAN_W-1:0]  from_west,
  input  logic [LOCAL_W-1:0] local_inputs,
  input  logic               ce_i,
  input  logic               cfg_en_i,
  input  logic               cfg_din_i,
  input  logic               cfg_commit_i,
`ifdef CLB_CARRY_EN
  input  logic               carry_i,
  output logic               carry_o,
`endif
  output logic               cfg_dout_o,
  output logic               cfg_valid_o,
  output logic [CHAN_W-1:0]  to_north,
  output logic [CHAN_W-1:0]  to_south,
  output logic [CHAN_W-1:0]  to_east,
  output logic [CHAN_W-1:0]  to_west,
  output logic [NUM_LE-1:0]  local_output
);

  localparam int NUM_SRC  = 4*CHAN_W + LOCAL_W + NUM_LE;
  localparam int SEL_W    = $clog2(NUM_SRC);
  localparam int ROUTE_W  = $clog2(NUM_LE + 1);
  localparam int LUT_N    = 2**LUT_K;
`ifdef CLB_CARRY_EN
  localparam int CARRY_B  = 1;
`else
  localparam int CARRY_B  = 0;
`endif
  localparam int LE_BITS  = LUT_K*SEL_W + LUT_N + 1 + CARRY_B;
  localparam int NUM_TRK  = 4*CHAN_W;
  localparam int CFG_BITS = NUM_LE*LE_BITS + NUM_TRK*ROUTE_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int SRC_PAD  = 2**SEL_W;
  localparam int Y_PAD    = 2**ROUTE_W;

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LE-1:0]   ff_q, ff_d;

  logic                cfg_valid_s;
  logic                commit_s;
  logic [NUM_SRC-1:0]  src_s;
  logic [SRC_PAD-1:0]  src_pad_s;
  logic [NUM_LE-1:0]   d_s;
  logic [NUM_LE-1:0]   y_s;
  logic [Y_PAD-1:0]    y_pad_s;
  logic [NUM_TRK-1:0]  trk_s;
  logic [NUM_LE:0]     cin_s;

  assign cfg_valid_s = (cnt_q == CNT_W'(CFG_BITS));
  assign commit_s    = cfg_commit_i & cfg_valid_s & ~cfg_en_i;

  // Feedback only from registered LE outputs; padding makes out-of-range selects read 0.
  assign src_s     = {ff_q, local_inputs, from_west, from_east, from_south, from_north};
  assign src_pad_s = SRC_PAD'(src_s);

`ifdef CLB_CARRY_EN
  assign cin_s[0] = carry_i;
  assign carry_o  = cin_s[NUM_LE];
`else
  assign cin_s    = '0;
`endif

  for (genvar j = 0; j < NUM_LE; j++) begin : g_le
    logic [LE_BITS-1:0] cfg_s;
    logic [LUT_K-1:0]   in_s;
    logic [LUT_N-1:0]   init_s;
    logic               lut_s;
    logic               use_ff_s;

    assign cfg_s    = active_q[j*LE_BITS +: LE_BITS];
    assign init_s   = cfg_s[LUT_K*SEL_W +: LUT_N];
    assign use_ff_s = cfg_s[LUT_K*SEL_W + LUT_N];

    for (genvar k = 0; k < LUT_K; k++) begin : g_in
      assign in_s[k] = src_pad_s[cfg_s[k*SEL_W +: SEL_W]];
    end

    assign lut_s = init_s[in_s];

`ifdef CLB_CARRY_EN
    logic carry_mode_s;
    assign carry_mode_s = cfg_s[LE_BITS-1];
    assign d_s[j]       = lut_s ^ (carry_mode_s & cin_s[j]);
    assign cin_s[j+1]   = carry_mode_s ? ((in_s[0] & in_s[1]) | (cin_s[j] & (in_s[0] ^ in_s[1])))
                                       : cin_s[j];
`else
    assign d_s[j] = lut_s;
`endif

    assign y_s[j] = use_ff_s ? ff_q[j] : d_s[j];
  end

  // Route code 0 and codes above NUM_LE land on the zero entries of the padded vector.
  assign y_pad_s = Y_PAD'({y_s, 1'b0});

  for (genvar t = 0; t < NUM_TRK; t++) begin : g_route
    logic [ROUTE_W-1:0] route_s;
    assign route_s  = active_q[NUM_LE*LE_BITS + t*ROUTE_W +: ROUTE_W];
    assign trk_s[t] = y_pad_s[route_s];
  end

  assign to_north     = trk_s[0*CHAN_W +: CHAN_W];
  assign to_south     = trk_s[1*CHAN_W +: CHAN_W];
  assign to_east      = trk_s[2*CHAN_W +: CHAN_W];
  assign to_west      = trk_s[3*CHAN_W +: CHAN_W];
  assign local_output = y_s;
  assign cfg_dout_o   = shadow_q[CFG_BITS-1];
  assign cfg_valid_o  = cfg_valid_s;

  // Next state: shifting freezes the LE registers; a commit clears them and swaps in the shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    ff_d     = ff_q;
    if (cfg_en_i) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], cfg_din_i};
      if (!cfg_valid_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (commit_s) begin
      active_d = shadow_q;
      ff_d     = '0;
      cnt_d    = '0;
    end else if (ce_i) begin
      ff_d = d_s;
    end else begin
      ff_d = ff_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ff_q     <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
    end
  end

endmodule

// File: tb/tb_clb_param.sv
// Directed self-checking bench for clb_param (default parameters); two tiles share a config chain.
module tb_clb_param;

`ifdef CLB_CARRY_EN
  localparam int LE_BITS = 34;
`else
  localparam int LE_BITS = 33;
`endif
  localparam int CFG_BITS = 2*LE_BITS + 16;

  logic       clk, rst_n;
  logic [1:0] from_north, from_south, from_east, from_west, local_inputs;
  logic       ce, cfg_en, cfg_din, cfg_commit;
  logic       carry_i, carry_o_a, carry_o_b;
  logic       dout_a, valid_a, dout_b, valid_b;
  logic [1:0] to_north_a, to_south_a, to_east_a, to_west_a, lo_a;
  logic [1:0] to_north_b, to_south_b, to_east_b, to_west_b, lo_b;

  int total = 0;
  int bad   = 0;

  logic [CFG_BITS-1:0] cfg_and_n, cfg_reg_n, cfg_and_e, cfg_or_s;

  clb_param u_dut_a (
`ifdef CLB_CARRY_EN
    .carry_i(carry_i), .carry_o(carry_o_a),
`endif
    .clk_i(clk), .rst_ni(rst_n),
    .from_north(from_north), .from_south(from_south), .from_east(from_east), .from_west(from_west),
    .local_inputs(local_inputs), .ce_i(ce), .cfg_en_i(cfg_en), .cfg_din_i(cfg_din),
    .cfg_commit_i(cfg_commit), .cfg_dout_o(dout_a), .cfg_valid_o(valid_a),
    .to_north(to_north_a), .to_south(to_south_a), .to_east(to_east_a), .to_west(to_west_a),
    .local_output(lo_a)
  );

  clb_param u_dut_b (
`ifdef CLB_CARRY_EN
    .carry_i(carry_i), .carry_o(carry_o_b),
`endif
    .clk_i(clk), .rst_ni(rst_n),
    .from_north(from_north), .from_south(from_south), .from_east(from_east), .from_west(from_west),
    .local_inputs(local_inputs), .ce_i(ce), .cfg_en_i(cfg_en), .cfg_din_i(dout_a),
    .cfg_commit_i(cfg_commit), .cfg_dout_o(dout_b), .cfg_valid_o(valid_b),
    .to_north(to_north_b), .to_south(to_south_b), .to_east(to_east_b), .to_west(to_west_b),
    .local_output(lo_b)
  );

`ifndef CLB_CARRY_EN
  assign carry_o_a = 1'b0;
  assign carry_o_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LE_BITS-1:0] make_le(input logic [3:0] s0, input logic [3:0] s1,
                                                 input logic [3:0] s2, input logic [3:0] s3,
                                                 input logic [15:0] init, input logic use_ff);
    logic [LE_BITS-1:0] v;
    v        = '0;
    v[3:0]   = s0;
    v[7:4]   = s1;
    v[11:8]  = s2;
    v[15:12] = s3;
    v[31:16] = init;
    v[32]    = use_ff;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(input logic [CFG_BITS-1:0] c, input int n);
    for (int i = CFG_BITS - 1; i >= CFG_BITS - n; i--) begin
      cfg_en  = 1'b1;
      cfg_din = c[i];
      tick();
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    from_north = 2'($urandom()); from_south = 2'($urandom());
    from_east  = 2'($urandom()); from_west  = 2'($urandom());
    local_inputs = 2'($urandom());
    ce = 1'b1; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0; carry_i = 1'b0;
    repeat (2) tick();
    total++;
    if ({to_north_a, to_south_a, to_east_a, to_west_a, lo_a} !== 10'd0) begin
      bad++; $display("FAIL reset_outs: got=%b exp=0", {to_north_a, to_south_a, to_east_a, to_west_a, lo_a});
    end
    total++;
    if ({valid_a, dout_a, valid_b, dout_b, carry_o_a, carry_o_b} !== 6'd0) begin
      bad++; $display("FAIL reset_cfg: got=%b exp=000000", {valid_a, dout_a, valid_b, dout_b, carry_o_a, carry_o_b});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({to_north_b, to_south_b, to_east_b, to_west_b, lo_b, to_north_a, lo_a} !== 14'd0) begin
      bad++; $display("FAIL reset_release: got=%b exp=0", {to_north_b, to_south_b, to_east_b, to_west_b, lo_b, to_north_a, lo_a});
    end
    from_north = 2'b00; from_south = 2'b00; from_east = 2'b00; from_west = 2'b00; local_inputs = 2'b00;
    ce = 1'b0;
  endtask

  task automatic test_comb_and();
    from_north = 2'b01; from_east = 2'b10;
    shift_cfg(cfg_and_n, CFG_BITS);
    total++;
    if (valid_a !== 1'b1 || to_north_a !== 2'b00) begin
      bad++; $display("FAIL and_preload: valid=%b to_north=%b exp valid=1 to_north=00", valid_a, to_north_a);
    end
    do_commit();
    total++;
    if (to_north_a !== 2'b01 || lo_a !== 2'b01 || valid_a !== 1'b0) begin
      bad++; $display("FAIL and_on: to_north=%b lo=%b valid=%b exp 01 01 0", to_north_a, lo_a, valid_a);
    end
    from_north = 2'b00; #1;
    total++;
    if (to_north_a !== 2'b00) begin
      bad++; $display("FAIL and_drop_north: to_north=%b exp=00", to_north_a);
    end
    from_north = 2'b01; from_east = 2'b01; #1;
    total++;
    if (to_north_a !== 2'b00) begin
      bad++; $display("FAIL and_drop_east: to_north=%b exp=00", to_north_a);
    end
    from_east = 2'b10; #1;
    total++;
    if (to_north_a !== 2'b01) begin
      bad++; $display("FAIL and_restore: to_north=%b exp=01", to_north_a);
    end
  endtask

  task automatic test_registered();
    ce = 1'b0;
    shift_cfg(cfg_reg_n, CFG_BITS);
    do_commit();
    total++;
    if (to_north_a !== 2'b00) begin
      bad++; $display("FAIL reg_after_commit: to_north=%b exp=00", to_north_a);
    end
    tick();
    total++;
    if (to_north_a !== 2'b00) begin
      bad++; $display("FAIL reg_ce0: to_north=%b exp=00", to_north_a);
    end
    ce = 1'b1;
    tick();
    total++;
    if (to_north_a !== 2'b01) begin
      bad++; $display("FAIL reg_ce1: to_north=%b exp=01", to_north_a);
    end
    from_north = 2'b00; ce = 1'b0; #1;
    total++;
    if (to_north_a !== 2'b01) begin
      bad++; $display("FAIL reg_comb_hold: to_north=%b exp=01", to_north_a);
    end
    tick();
    total++;
    if (to_north_a !== 2'b01) begin
      bad++; $display("FAIL reg_hold_ce0: to_north=%b exp=01", to_north_a);
    end
    ce = 1'b1; cfg_en = 1'b1; cfg_din = 1'b0;
    tick();
    cfg_en = 1'b0;
    total++;
    if (to_north_a !== 2'b01) begin
      bad++; $display("FAIL reg_hold_shift: to_north=%b exp=01", to_north_a);
    end
    tick();
    total++;
    if (to_north_a !== 2'b00) begin
      bad++; $display("FAIL reg_update: to_north=%b exp=00", to_north_a);
    end
    ce = 1'b0;
  endtask

  task automatic test_commit_guards();
    from_north = 2'b01; from_east = 2'b10;
    shift_cfg(cfg_and_n, CFG_BITS);
    do_commit();
    shift_cfg(cfg_and_e, CFG_BITS - 1);
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL guard_valid81: valid=%b exp=0", valid_a);
    end
    do_commit();
    total++;
    if (to_north_a !== 2'b01 || to_east_a !== 2'b00) begin
      bad++; $display("FAIL guard_81_ignored: north=%b east=%b exp 01 00", to_north_a, to_east_a);
    end
    cfg_en = 1'b1; cfg_din = cfg_and_e[0];
    tick();
    cfg_en = 1'b0;
    total++;
    if (valid_a !== 1'b1) begin
      bad++; $display("FAIL guard_valid82: valid=%b exp=1", valid_a);
    end
    cfg_en = 1'b1; cfg_din = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    total++;
    if (to_north_a !== 2'b01 || to_east_a !== 2'b00 || valid_a !== 1'b1) begin
      bad++; $display("FAIL guard_en_ignored: north=%b east=%b valid=%b exp 01 00 1", to_north_a, to_east_a, valid_a);
    end
    shift_cfg(cfg_and_e, CFG_BITS);
    do_commit();
    total++;
    if (to_north_a !== 2'b00 || to_east_a !== 2'b01 || valid_a !== 1'b0) begin
      bad++; $display("FAIL guard_applied: north=%b east=%b valid=%b exp 00 01 0", to_north_a, to_east_a, valid_a);
    end
  endtask

  task automatic test_daisy_chain();
    logic [2*CFG_BITS-1:0] stream;
    int dout_bad;
    dout_bad = 0;
    stream = {cfg_or_s, cfg_and_n};
    for (int k = 0; k < 2*CFG_BITS; k++) begin
      cfg_en  = 1'b1;
      cfg_din = stream[2*CFG_BITS-1-k];
      tick();
      if (k + 1 >= CFG_BITS) begin
        total++;
        if (dout_a !== stream[2*CFG_BITS-1-(k+1-CFG_BITS)]) begin
          bad++; dout_bad++;
          if (dout_bad < 5) $display("FAIL chain_dout: shift=%0d got=%b exp=%b", k + 1, dout_a,
                                     stream[2*CFG_BITS-1-(k+1-CFG_BITS)]);
        end
      end
    end
    cfg_en = 1'b0;
    total++;
    if (valid_a !== 1'b1 || valid_b !== 1'b1) begin
      bad++; $display("FAIL chain_valid: a=%b b=%b exp 1 1", valid_a, valid_b);
    end
    do_commit();
    from_north = 2'b01; from_east = 2'b00; #1;
    total++;
    if (to_north_a !== 2'b00 || to_south_b !== 2'b01) begin
      bad++; $display("FAIL chain_n_only: a_north=%b b_south=%b exp 00 01", to_north_a, to_south_b);
    end
    from_north = 2'b00; from_east = 2'b10; #1;
    total++;
    if (to_north_a !== 2'b00 || to_south_b !== 2'b01) begin
      bad++; $display("FAIL chain_e_only: a_north=%b b_south=%b exp 00 01", to_north_a, to_south_b);
    end
    from_north = 2'b01; #1;
    total++;
    if (to_north_a !== 2'b01 || to_south_b !== 2'b01 || lo_b !== 2'b01) begin
      bad++; $display("FAIL chain_both: a_north=%b b_south=%b b_lo=%b exp 01 01 01", to_north_a, to_south_b, lo_b);
    end
    from_north = 2'b00; from_east = 2'b00; #1;
    total++;
    if ({to_south_b, to_north_b, to_east_b, to_west_b, to_south_a} !== 10'd0) begin
      bad++; $display("FAIL chain_none: got=%b exp=0", {to_south_b, to_north_b, to_east_b, to_west_b, to_south_a});
    end
  endtask

`ifdef CLB_CARRY_EN
  task automatic test_carry();
    logic [LE_BITS-1:0] le0, le1;
    le0 = make_le(4'd0, 4'd4, 4'd15, 4'd15, 16'h6666, 1'b0);
    le1 = make_le(4'd1, 4'd5, 4'd15, 4'd15, 16'h6666, 1'b0);
    le0[33] = 1'b1;
    le1[33] = 1'b1;
    shift_cfg({16'h0009, le1, le0}, CFG_BITS);
    do_commit();
    from_north = 2'b11; from_east = 2'b01; carry_i = 1'b1; #1;
    total++;
    if (to_north_a !== 2'b01 || carry_o_a !== 1'b1) begin
      bad++; $display("FAIL carry_cin1: sum=%b cout=%b exp 01 1", to_north_a, carry_o_a);
    end
    carry_i = 1'b0; #1;
    total++;
    if (to_north_a !== 2'b00 || carry_o_a !== 1'b1) begin
      bad++; $display("FAIL carry_cin0: sum=%b cout=%b exp 00 1", to_north_a, carry_o_a);
    end
    from_north = 2'b01; from_east = 2'b00; #1;
    total++;
    if (to_north_a !== 2'b01 || carry_o_a !== 1'b0) begin
      bad++; $display("FAIL carry_small: sum=%b cout=%b exp 01 0", to_north_a, carry_o_a);
    end
  endtask
`endif

  task automatic test_reset_midshift();
    logic [CFG_BITS-1:0] ones;
    ones = '1;
    from_north = 2'b01; from_east = 2'b10;
    shift_cfg(cfg_and_n, CFG_BITS);
    do_commit();
    shift_cfg(ones, CFG_BITS);
    total++;
    if (dout_a !== 1'b1 || to_north_a !== 2'b01) begin
      bad++; $display("FAIL mid_pre: dout=%b north=%b exp 1 01", dout_a, to_north_a);
    end
    cfg_en = 1'b1; cfg_din = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (dout_a !== 1'b0 || valid_a !== 1'b0 || to_north_a !== 2'b00 || lo_a !== 2'b00) begin
      bad++; $display("FAIL mid_reset: dout=%b valid=%b north=%b lo=%b exp 0 0 00 00", dout_a, valid_a, to_north_a, lo_a);
    end
    cfg_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (to_north_a !== 2'b00 || valid_a !== 1'b0) begin
      bad++; $display("FAIL mid_after: north=%b valid=%b exp 00 0", to_north_a, valid_a);
    end
  endtask

  initial begin
    cfg_and_n = {16'h0001, {LE_BITS{1'b0}}, make_le(4'd0, 4'd5, 4'd15, 4'd15, 16'h8888, 1'b0)};
    cfg_reg_n = {16'h0001, {LE_BITS{1'b0}}, make_le(4'd0, 4'd5, 4'd15, 4'd15, 16'h8888, 1'b1)};
    cfg_and_e = {16'h0100, {LE_BITS{1'b0}}, make_le(4'd0, 4'd5, 4'd15, 4'd15, 16'h8888, 1'b0)};
    cfg_or_s  = {16'h0010, {LE_BITS{1'b0}}, make_le(4'd0, 4'd5, 4'd15, 4'd15, 16'hEEEE, 1'b0)};
    test_reset();
    test_comb_and();
    test_registered();
    test_commit_guards();
    test_daisy_chain();
`ifdef CLB_CARRY_EN
    test_carry();
`endif
    test_reset_midshift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
